// File: rtl/weight_bias_stream_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : weight_bias_stream_loader_if
//  Description : Byte-stream input and weight/bias BRAM write bus of the
//                classifier model loader.
//                master : stream source (drives rx_data, rx_valid, reload)
//                slave  : loader (drives the BRAM write ports and status)
//  Signals     : rx_data[7:0], rx_valid, reload           (source -> loader)
//                weight_we, weight_waddr[12:0], weight_wdata[7:0],
//                bias_we, bias_waddr[3:0], bias_wdata[31:0],
//                weights_ready, loading, load_error         (loader -> out)
//  Revision    : 1.0 - initial release
// ============================================================================
interface weight_bias_stream_loader_if;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        reload;
   logic        weight_we;
   logic [12:0] weight_waddr;
   logic [7:0]  weight_wdata;
   logic        bias_we;
   logic [3:0]  bias_waddr;
   logic [31:0] bias_wdata;
   logic        weights_ready;
   logic        loading;
   logic        load_error;

   modport master (
      output rx_data, rx_valid, reload,
      input  weight_we, weight_waddr, weight_wdata,
      input  bias_we, bias_waddr, bias_wdata,
      input  weights_ready, loading, load_error
   );

   modport slave (
      input  rx_data, rx_valid, reload,
      output weight_we, weight_waddr, weight_wdata,
      output bias_we, bias_waddr, bias_wdata,
      output weights_ready, loading, load_error
   );
endinterface
`default_nettype wire

// File: rtl/weight_bias_stream_loader.sv
`default_nettype none
// ============================================================================
//  Module      : weight_bias_stream_loader
//  Description : Writes a streamed classifier model into the weight BRAM
//                (NUM_WEIGHTS signed bytes) and bias BRAM (NUM_BIASES
//                little-endian 32-bit words), then raises weights_ready.
//                Optional macro CHECKSUM_LOADER_EN adds a trailer byte that
//                must equal the mod-256 sum of all payload bytes.
//  Ports       : clk, rst_n (async, active low)
//                bus (slave modport of weight_bias_stream_loader_if):
//                  rx_data/rx_valid byte strobe, reload restart pulse,
//                  weight_we/waddr/wdata, bias_we/waddr/wdata write ports,
//                  weights_ready, loading, load_error status
//  Revision    : 1.0 - initial release
// ============================================================================
module weight_bias_stream_loader #(
   parameter int NUM_WEIGHTS    = 7840,
   parameter int NUM_BIASES     = 10,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                        clk,
   input  logic                        rst_n,
   weight_bias_stream_loader_if.slave  bus
);

   localparam logic [12:0] W_LAST     = 13'(NUM_WEIGHTS - 1);
   localparam logic [3:0]  B_LAST     = 4'(NUM_BIASES - 1);
   localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
   localparam int          IDLE_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   // Abort fires on the TIMEOUT_CYCLES-th consecutive idle cycle.
   localparam logic [IDLE_W-1:0] IDLE_LAST =
      IDLE_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   typedef enum logic [1:0] {
      S_WEIGHTS = 2'd0,
      S_BIAS    = 2'd1,
      S_CHECK   = 2'd2,
      S_READY   = 2'd3
   } state_t;

   state_t            state;
   logic [12:0]       weight_cnt;
   logic [3:0]        bias_idx;
   logic [1:0]        byte_idx;
   logic [23:0]       bias_lo;      // lower three bytes of the word in flight
   logic [IDLE_W-1:0] idle_cnt;
`ifdef CHECKSUM_LOADER_EN
   logic [7:0]        sum;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state              <= S_WEIGHTS;
         weight_cnt         <= '0;
         bias_idx           <= '0;
         byte_idx           <= '0;
         bias_lo            <= '0;
         idle_cnt           <= '0;
`ifdef CHECKSUM_LOADER_EN
         sum                <= '0;
`endif
         bus.weight_we      <= 1'b0;
         bus.weight_waddr   <= '0;
         bus.weight_wdata   <= '0;
         bus.bias_we        <= 1'b0;
         bus.bias_waddr     <= '0;
         bus.bias_wdata     <= '0;
         bus.weights_ready  <= 1'b0;
         bus.loading        <= 1'b0;
         bus.load_error     <= 1'b0;
      end else begin
         bus.weight_we <= 1'b0;
         bus.bias_we   <= 1'b0;

         if (bus.reload) begin
            // Any byte arriving together with reload is dropped.
            state             <= S_WEIGHTS;
            weight_cnt        <= '0;
            bias_idx          <= '0;
            byte_idx          <= '0;
            bias_lo           <= '0;
            idle_cnt          <= '0;
`ifdef CHECKSUM_LOADER_EN
            sum               <= '0;
`endif
            bus.weights_ready <= 1'b0;
            bus.loading       <= 1'b0;
            bus.load_error    <= 1'b0;
         end else if (bus.rx_valid && state != S_READY) begin
            idle_cnt    <= '0;
            bus.loading <= 1'b1;
            // First byte of a new load clears a stale abort flag.
            if (!bus.loading)
               bus.load_error <= 1'b0;
`ifdef CHECKSUM_LOADER_EN
            if (state != S_CHECK)
               sum <= sum + bus.rx_data;
`endif
            case (state)
               S_WEIGHTS: begin
                  bus.weight_we    <= 1'b1;
                  bus.weight_waddr <= weight_cnt;
                  bus.weight_wdata <= bus.rx_data;
                  // Count stops at the last address; the next byte is bias data.
                  if (weight_cnt == W_LAST)
                     state <= S_BIAS;
                  else
                     weight_cnt <= weight_cnt + 13'd1;
               end
               S_BIAS: begin
                  if (byte_idx == 2'd3) begin
                     bus.bias_we    <= 1'b1;
                     bus.bias_waddr <= bias_idx;
                     bus.bias_wdata <= {bus.rx_data, bias_lo};
                     byte_idx       <= '0;
                     if (bias_idx == B_LAST) begin
`ifdef CHECKSUM_LOADER_EN
                        state <= S_CHECK;
`else
                        state             <= S_READY;
                        bus.weights_ready <= 1'b1;
                        bus.loading       <= 1'b0;
`endif
                     end else begin
                        bias_idx <= bias_idx + 4'd1;
                     end
                  end else begin
                     // Shift right so byte 0 ends up in bits [7:0].
                     bias_lo  <= {bus.rx_data, bias_lo[23:8]};
                     byte_idx <= byte_idx + 2'd1;
                  end
               end
`ifdef CHECKSUM_LOADER_EN
               S_CHECK: begin
                  if (bus.rx_data == sum) begin
                     state             <= S_READY;
                     bus.weights_ready <= 1'b1;
                     bus.loading       <= 1'b0;
                  end else begin
                     state          <= S_WEIGHTS;
                     weight_cnt     <= '0;
                     bias_idx       <= '0;
                     byte_idx       <= '0;
                     bias_lo        <= '0;
                     sum            <= '0;
                     bus.loading    <= 1'b0;
                     bus.load_error <= 1'b1;
                  end
               end
`endif
               default: ;
            endcase
         end else if (TIMEOUT_EN && bus.loading) begin
            // loading is only set in the receiving states, so it doubles as
            // the "at least one byte received" qualifier.
            if (idle_cnt == IDLE_LAST) begin
               state          <= S_WEIGHTS;
               weight_cnt     <= '0;
               bias_idx       <= '0;
               byte_idx       <= '0;
               bias_lo        <= '0;
               idle_cnt       <= '0;
`ifdef CHECKSUM_LOADER_EN
               sum            <= '0;
`endif
               bus.loading    <= 1'b0;
               bus.load_error <= 1'b1;
            end else begin
               idle_cnt <= idle_cnt + IDLE_W'(1);
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_weight_bias_stream_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_weight_bias_stream_loader
//  Description : Scoreboard bench for weight_bias_stream_loader. The driver
//                feeds random/directed model streams and pushes the expected
//                BRAM writes from a byte-position model; a negedge monitor
//                pops and compares every write strobe. Honours the
//                CHECKSUM_LOADER_EN macro (trailer byte).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_weight_bias_stream_loader;
   localparam int NW = 7840;
   localparam int NB = 10;
   localparam int TO = 100;
`ifdef CHECKSUM_LOADER_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   weight_bias_stream_loader_if bus ();

   weight_bias_stream_loader #(
      .NUM_WEIGHTS    (NW),
      .NUM_BIASES     (NB),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      int          addr;
      logic [31:0] data;
      bit          ready;
   } wr_t;

   wr_t wq[$];
   wr_t bq[$];

   int n_tests = 0;
   int n_fail  = 0;
   int n_wwe   = 0;
   int n_bwe   = 0;

   // Reference model: position of the next byte inside the current load.
   int         m_pos;
   bit         m_ready, m_loading, m_error;
   logic [7:0] m_sum;
   logic [7:0] m_bb[$];

   logic [7:0]  lw [NW];
   logic [31:0] lb [NB];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic void model_clear();
      m_pos   = 0;
      m_sum   = 8'h00;
      m_ready = 1'b0;
      m_bb.delete();
   endfunction

   function automatic void model_byte(input logic [7:0] b);
      wr_t e;
      if (m_ready) return;
      if (!m_loading) m_error = 1'b0;
      m_loading = 1'b1;
      if (m_pos < NW) begin
         e.addr = m_pos; e.data = {24'd0, b}; e.ready = 1'b0;
         wq.push_back(e);
      end else if (m_pos < NW + 4 * NB) begin
         m_bb.push_back(b);
         if (m_bb.size() == 4) begin
            e.addr  = (m_pos - NW) / 4;
            e.data  = {m_bb[3], m_bb[2], m_bb[1], m_bb[0]};
            e.ready = (e.addr == NB - 1) && !CHK;
            bq.push_back(e);
            m_bb.delete();
            if (e.ready) begin
               m_ready   = 1'b1;
               m_loading = 1'b0;
            end
         end
      end else begin
         // Trailer byte (checksum builds only).
         if (b == m_sum) begin
            m_ready   = 1'b1;
            m_loading = 1'b0;
         end else begin
            model_clear();
            m_loading = 1'b0;
            m_error   = 1'b1;
         end
         return;
      end
      m_sum = m_sum + b;
      m_pos++;
   endfunction

   // Monitor: every write strobe must match the oldest expected write.
   always @(negedge clk) begin
      wr_t e;
      if (bus.weight_we) begin
         n_wwe++;
         if (wq.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL weight_we: unexpected strobe addr 0x%0h, expected none", bus.weight_waddr);
         end else begin
            e = wq.pop_front();
            check("weight_waddr", {19'd0, bus.weight_waddr}, e.addr);
            check("weight_wdata", {24'd0, bus.weight_wdata}, e.data);
         end
      end
      if (bus.bias_we) begin
         n_bwe++;
         if (bq.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL bias_we: unexpected strobe addr 0x%0h, expected none", bus.bias_waddr);
         end else begin
            e = bq.pop_front();
            check("bias_waddr", {28'd0, bus.bias_waddr}, e.addr);
            check("bias_wdata", bus.bias_wdata, e.data);
            check("weights_ready with bias_we", {31'd0, bus.weights_ready}, {31'd0, e.ready});
         end
      end
   end

   // Called at a negedge; returns at a negedge with the byte's effect visible.
   task automatic send_byte(input logic [7:0] b);
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      model_byte(b);
      @(negedge clk);
      bus.rx_valid = 1'b0;
      if ($urandom_range(0, 3) == 0) @(negedge clk);
   endtask

   task automatic pulse_reload(input bit with_byte);
      bus.reload = 1'b1;
      if (with_byte) begin
         bus.rx_valid = 1'b1;
         bus.rx_data  = 8'($urandom);
      end
      model_clear();
      m_loading = 1'b0;
      m_error   = 1'b0;
      @(negedge clk);
      bus.reload   = 1'b0;
      bus.rx_valid = 1'b0;
   endtask

   task automatic send_weights();
      for (int i = 0; i < NW; i++) send_byte(lw[i]);
   endtask

   task automatic send_biases();
      for (int k = 0; k < NB; k++)
         for (int j = 0; j < 4; j++) send_byte(lb[k][8*j +: 8]);
`ifdef CHECKSUM_LOADER_EN
      send_byte(m_sum);
`endif
   endtask

   task automatic randomize_model();
      for (int i = 0; i < NW; i++) lw[i] = 8'($urandom);
      for (int k = 0; k < NB; k++) lb[k] = $urandom;
   endtask

   task automatic check_flags(input string tag);
      check({tag, " weights_ready"}, {31'd0, bus.weights_ready}, {31'd0, m_ready});
      check({tag, " loading"},       {31'd0, bus.loading},       {31'd0, m_loading});
      check({tag, " load_error"},    {31'd0, bus.load_error},    {31'd0, m_error});
   endtask

   task automatic check_drained(input string tag);
      repeat (3) @(negedge clk);
      check({tag, " weight writes missing"}, wq.size(), 0);
      check({tag, " bias writes missing"},   bq.size(), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int w0, b0;
      bus.rx_data  = 8'h00;
      bus.rx_valid = 1'b0;
      bus.reload   = 1'b0;
      model_clear();
      m_loading = 1'b0;
      m_error   = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      check("reset weight_we",     {31'd0, bus.weight_we},     0);
      check("reset bias_we",       {31'd0, bus.bias_we},       0);
      check("reset weight_waddr",  {19'd0, bus.weight_waddr},  0);
      check("reset bias_wdata",    bus.bias_wdata,             0);
      check_flags("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // 1: ramp weights, biases 0x1000+k
      for (int i = 0; i < NW; i++) lw[i] = 8'(i);
      for (int k = 0; k < NB; k++) lb[k] = 32'h0000_1000 + 32'(k);
      w0 = n_wwe; b0 = n_bwe;
      send_weights();
      check_flags("t1 after weights");
      send_biases();
      check_flags("t1 done");
      check_drained("t1");
      check("t1 weight_we count", n_wwe - w0, NW);
      check("t1 bias_we count",   n_bwe - b0, NB);
      check("t1 held weight_waddr", {19'd0, bus.weight_waddr}, NW - 1);
      check("t1 held weight_wdata", {24'd0, bus.weight_wdata}, 32'h9F);
      check("t1 held bias_waddr",   {28'd0, bus.bias_waddr},   NB - 1);
      check("t1 held bias_wdata",   bus.bias_wdata,            32'h0000_1009);

      // 2: little-endian assembly incl. all-ones word
      pulse_reload(1'b0);
      check_flags("t2 after reload");
      randomize_model();
      lb[0] = 32'h1234_5678;
      lb[1] = 32'hFFFF_FFFF;
      send_weights();
      send_biases();
      check_flags("t2 done");
      check_drained("t2");

      // 3: reload mid-load (with a colliding byte), then a full new load
      pulse_reload(1'b0);
      randomize_model();
      for (int i = 0; i < 500; i++) send_byte(lw[i]);
      check_flags("t3 partial");
      pulse_reload(1'b1);
      check_flags("t3 after reload");
      randomize_model();
      send_weights();
      check_flags("t3 weights only");
      send_biases();
      check_flags("t3 done");
      check_drained("t3");

      // 4: timeout after 20 bytes
      pulse_reload(1'b0);
      for (int i = 0; i < 20; i++) send_byte(8'($urandom));
      repeat (90) @(negedge clk);
      check_flags("t4 before timeout");
      repeat (15) @(negedge clk);
      model_clear();
      m_loading = 1'b0;
      m_error   = 1'b1;
      check_flags("t4 timed out");
      send_byte(8'($urandom));
      check_flags("t4 restart");
      check_drained("t4");

      // 5: bytes after ready are ignored; async reset mid-load
      pulse_reload(1'b0);
      randomize_model();
      send_weights();
      send_biases();
      check_flags("t5 ready");
      for (int i = 0; i < 5; i++) send_byte(8'($urandom));
      check_drained("t5 extra bytes");
      check_flags("t5 still ready");
      pulse_reload(1'b0);
      for (int i = 0; i < 300; i++) send_byte(8'($urandom));
      check_drained("t5 partial");
      rst_n = 1'b0;
      #1;
      model_clear();
      m_loading = 1'b0;
      m_error   = 1'b0;
      check_flags("t5 async reset");
      check("t5 async reset weight_waddr", {19'd0, bus.weight_waddr}, 0);
      check("t5 async reset weight_wdata", {24'd0, bus.weight_wdata}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

`ifdef CHECKSUM_LOADER_EN
      // 6: wrong trailer aborts the load
      randomize_model();
      send_weights();
      for (int k = 0; k < NB; k++)
         for (int j = 0; j < 4; j++) send_byte(lb[k][8*j +: 8]);
      send_byte(m_sum ^ 8'h01);
      check_flags("t6 bad trailer");
      send_byte(8'($urandom));
      check_flags("t6 restart");
      check_drained("t6");
`endif

      check_drained("final");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/weight_bias_stream_loader.md
Name: weight_bias_stream_loader

Overview:
Writer side of the classifier's weight/bias memories. Consumes a byte stream (UART RX strobe style) carrying 7840 signed int8 weights, then 10 little-endian 32-bit signed biases. Writes them into the weight BRAM (13-bit address) and bias BRAM (4-bit address) that the softmax inference engine reads. Raises weights_ready once a complete model is stored.

Parameters:
NUM_WEIGHTS, 7840, weight bytes per load (10 classes x 784 pixels)
NUM_BIASES, 10, bias words per load (4 bytes each)
TIMEOUT_CYCLES, 1000000, idle cycles mid-load before abort; 0 disables timeout

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rx_data  in  8  received byte
rx_valid  in  1  one-cycle strobe, rx_data valid
reload  in  1  pulse: discard current model, restart load
weight_we  out  1  weight BRAM write enable (1-cycle pulse)
weight_waddr  out  13  weight address 0..NUM_WEIGHTS-1
weight_wdata  out  8  weight byte
bias_we  out  1  bias BRAM write enable (1-cycle pulse)
bias_waddr  out  4  bias address 0..NUM_BIASES-1
bias_wdata  out  32  assembled bias word
weights_ready  out  1  complete model stored
loading  out  1  load in progress (>=1 byte accepted, not ready)
load_error  out  1  sticky abort flag (timeout or checksum)

Behaviour:
- Reset (rst_n low, async): state S_WEIGHTS; weight/bias/byte counters 0; all outputs 0.
- States: S_WEIGHTS -> S_BIAS -> [S_CHECK if CHECKSUM_LOADER_EN] -> S_READY.
- S_WEIGHTS: each rx_valid -> next cycle weight_we=1, weight_waddr=weight count, weight_wdata=rx_data; count++. Byte NUM_WEIGHTS-1 -> S_BIAS.
- S_BIAS: bytes shift in little-endian (byte0 = bits[7:0]). On the 4th byte -> next cycle bias_we=1, bias_waddr=bias index, bias_wdata=full word; index++. Last word -> S_READY (or S_CHECK).
- weights_ready goes high in the same cycle as the final bias_we (no checksum). It stays high until reload or reset.
- loading: set on the first accepted byte; cleared when weights_ready rises, on abort, or on reload.
- load_error: cleared on reload or on the first byte of a new load.
- S_READY: rx_valid ignored; no write strobes.
- Write strobes never assert without a preceding rx_valid. Addresses hold their last value when idle.
- reload (any state): next cycle S_WEIGHTS, counters 0, weights_ready=0, loading=0, load_error=0, partial bias word discarded. reload wins over a simultaneous rx_valid; that byte is dropped.
- Timeout: in S_WEIGHTS/S_BIAS/S_CHECK with >=1 byte received, the idle counter resets on every rx_valid. Reaching TIMEOUT_CYCLES -> S_WEIGHTS, counters 0, loading=0, load_error=1. Memory contents are left as-is; weights_ready stays 0.
- Counters saturate by construction: weight count max NUM_WEIGHTS-1, bias index max NUM_BIASES-1; no wrap into the next region.

Optional Feature:
Macro CHECKSUM_LOADER_EN.
- Defined:
  - Running 8-bit sum (mod 256) over all NUM_WEIGHTS + 4*NUM_BIASES payload bytes.
  - After the last bias, S_CHECK waits for one trailer byte.
  - Trailer equal to sum -> S_READY, weights_ready=1 one cycle after the trailer strobe.
  - Trailer not equal -> load_error=1, return to S_WEIGHTS, counters and sum cleared, weights_ready stays 0.
- Undefined: no trailer byte; ready follows the final bias write directly.

Test Plan:
1. Reset, stream weights byte i = i[7:0], biases k = 0x0000_1000+k -> 7840 weight_we pulses (addr 7839 data 0x9F), 10 bias_we (addr 9 data 0x00001009), weights_ready=1 with the last bias_we.
2. Bias bytes 0x78,0x56,0x34,0x12 for bias 0 -> bias_wdata=0x12345678, bias_waddr=0. Bytes 0xFF,0xFF,0xFF,0xFF -> 0xFFFFFFFF (-1).
3. Pulse reload after 500 weight bytes, then a full stream -> first subsequent weight_waddr=0, weights_ready only after the full new load.
4. TIMEOUT_CYCLES=100, stop after 20 bytes for 100 cycles -> load_error=1, loading=0; next byte written at addr 0, load_error cleared.
5. After weights_ready, send 5 extra bytes -> no weight_we/bias_we, weights_ready stays 1. Assert rst_n low mid-load -> all outputs 0 immediately.
6. CHECKSUM_LOADER_EN: correct trailer -> weights_ready=1; trailer = sum^0x01 -> load_error=1, weights_ready=0, next byte writes weight addr 0.
